// File: rtl/buf_retire_queue.sv
// In-order hold-and-release queue for granted buffer addresses. Each entry ages
// to HOLD_MIN before it may retire; a retire produces a registered free pulse.
module buf_retire_queue #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int HOLD_MIN = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          grant_valid,
    input  logic [AW-1:0] grant_addr,
    input  logic          retire_req,
    output logic          retire_ack,
    output logic          free_raw,
    output logic [AW-1:0] free_addr_raw,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow_err,
    output logic          dup_err
);

    localparam logic [7:0]  HOLD    = 8'(HOLD_MIN);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [7:0]       age_reg  [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             free_reg;
    logic [AW-1:0]    free_addr_reg;
    logic             overflow_reg;
    logic             dup_reg;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] match;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_C);
    assign pop   = retire_req & ~empty & (age_reg[rd_ptr_reg] == HOLD);
    assign push  = grant_valid & (~full | pop);

    assign retire_ack    = pop;
    assign free_raw      = free_reg;
    assign free_addr_raw = free_addr_reg;
    assign count         = count_reg;
    assign overflow_err  = overflow_reg;
    assign dup_err       = dup_reg;

    // The entry leaving this cycle no longer counts as held for the dup check.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] & (addr_mem[gi] == grant_addr)
                             & ~(pop & (rd_ptr_reg == AW'(gi)));
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= grant_addr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_reg[i] <= '0;
            end
            valid_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            free_reg      <= 1'b0;
            free_addr_reg <= '0;
            overflow_reg  <= 1'b0;
            dup_reg       <= 1'b0;
        end else begin
            // A write into the slot being popped (full, push+pop) wins.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_ptr_reg == AW'(i)) begin
                    age_reg[i]   <= '0;
                    valid_reg[i] <= 1'b1;
                end else begin
                    if (pop && rd_ptr_reg == AW'(i)) begin
                        valid_reg[i] <= 1'b0;
                    end
                    if (valid_reg[i] && age_reg[i] < HOLD) begin
                        age_reg[i] <= age_reg[i] + 8'd1;
                    end
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                free_addr_reg <= addr_mem[rd_ptr_reg];
            end
            free_reg  <= pop;
            count_reg <= count_next;
            if (grant_valid && full && !pop) begin
                overflow_reg <= 1'b1;
            end
            if (grant_valid && (|match)) begin
                dup_reg <= 1'b1;
            end
        end
    end

endmodule
